// File: rtl/delay_mem_arbiter_pkg.sv
// delay_mem_arbiter_pkg: shared sizing constants and pipeline indices for the delay memory arbiter
package delay_mem_arbiter_pkg;
  localparam int DELAY_BANK_BITS = 21;
  localparam int DELAY_MAX_OUTSTANDING = 8;
  localparam logic PIPE0 = 1'b0;
  localparam logic PIPE1 = 1'b1;
endpackage

// File: rtl/delay_mem_arbiter_tag_fifo.sv
// tag_fifo: 1-bit wide synchronous FIFO recording which pipeline issued each outstanding read
module tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
  logic [DEPTH-1:0] tags;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  assign full = count == FULL_COUNT;
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = tags[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        tags[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/delay_mem_arbiter.sv
// delay_mem_arbiter: per-pipeline bump allocation of delay memory banks plus round-robin access arbitration
module delay_mem_arbiter
  import delay_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DELAY_BANK_BITS + 1,
  parameter int DATA_WIDTH = 16,
  parameter int SIZE_WIDTH = 32,
  parameter int MAX_OUTSTANDING = DELAY_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    alloc_req,
  input  logic [SIZE_WIDTH-1:0]         alloc_size,
  input  logic [SIZE_WIDTH-1:0]         alloc_init,
  input  logic [1:0]                    full_reset,
  output logic [1:0]                    alloc_done,
  output logic [1:0]                    alloc_fail,
  output logic [2*(ADDR_WIDTH-1)-1:0]   alloc_base,
  input  logic [1:0]                    req_valid,
  input  logic [1:0]                    req_we,
  input  logic [2*(ADDR_WIDTH-1)-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata,
  output logic [1:0]                    req_grant,
  output logic [1:0]                    rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ready,
  input  logic                          mem_rvalid,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          protocol_error
);
  localparam int BW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH:0] BANK_WORDS = {2'b01, {BW{1'b0}}};
  for (genvar i = 0; i < 2; i++) begin : g_alloc
    logic [ADDR_WIDTH-1:0] free_ptr;
    logic [ADDR_WIDTH:0] end_ptr;
    logic [BW-1:0] base;
    logic done, fail, ok;
    // one spare bit keeps oversized requests from wrapping past the bank limit
    assign end_ptr = {1'b0, free_ptr} + {1'b0, alloc_size[ADDR_WIDTH-1:0]};
    assign ok = (alloc_size != '0) && (alloc_init <= alloc_size) && (end_ptr <= BANK_WORDS)
                && ((alloc_size >> ADDR_WIDTH) == '0);
    assign alloc_base[i*BW +: BW] = base;
    assign alloc_done[i] = done;
    assign alloc_fail[i] = fail;
    always_ff @(posedge clk) begin
      if (reset || full_reset[i]) begin
        free_ptr <= '0;
        base <= '0;
        done <= 1'b0;
        fail <= 1'b0;
      end else begin
        done <= alloc_req[i] & ok;
        fail <= alloc_req[i] & ~ok;
        if (alloc_req[i] && ok) begin
          base <= free_ptr[BW-1:0];
          free_ptr <= end_ptr[ADDR_WIDTH-1:0];
        end
      end
    end
  end
  logic [1:0] cand;
  logic last_grant, win, any, push, pop, head, full, empty;
  assign cand = req_valid & (req_we | {2{~full}});
  assign any = mem_ready & |cand;
  assign win = &cand ? ~last_grant : (cand[PIPE1] ? PIPE1 : PIPE0);
  assign req_grant = any ? (win == PIPE1 ? 2'b10 : 2'b01) : 2'b00;
  assign mem_req = any;
  assign mem_we = any & req_we[win];
  assign mem_addr = !any ? '0 : win ? {1'b1, req_addr[2*BW-1:BW]} : {1'b0, req_addr[BW-1:0]};
  assign mem_wdata = !any ? '0 : win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign push = any & ~req_we[win];
  assign pop = mem_rvalid & ~empty;
  tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(win),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_valid <= 2'b00;
      rd_data <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (any) last_grant <= win;
      rd_valid <= pop ? (head == PIPE1 ? 2'b10 : 2'b01) : 2'b00;
      if (pop) rd_data <= mem_rdata;
      if (mem_rvalid && empty) protocol_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_delay_mem_arbiter.sv
// tb_delay_mem_arbiter: allocation vector table, directed arbitration sequences and a randomized reference-model run
module tb_delay_mem_arbiter;
  localparam int AW = 22, DW = 16, SW = 32, BW = 21;
  logic clk = 1'b0, reset;
  logic [1:0] alloc_req, full_reset, alloc_done, alloc_fail, req_valid, req_we, req_grant, rd_valid;
  logic [SW-1:0] alloc_size, alloc_init;
  logic [2*BW-1:0] alloc_base, req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic mem_req, mem_we, mem_ready, mem_rvalid, protocol_error;
  logic [AW-1:0] mem_addr;
  int tests = 0, fails = 0;

  typedef struct {
    logic [1:0] req, frst, done, fail;
    logic [SW-1:0] size, init;
    logic [BW-1:0] b0, b1;
  } alloc_vec_t;
  typedef struct {
    int due;
    logic [DW-1:0] data;
  } rsp_t;

  alloc_vec_t av[13];
  rsp_t rsp[$];
  int tagq[$];
  logic last, w, granted;
  logic [1:0] cand, exp_rv;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] exp_addr;
  int last_due;

  always #5 clk = ~clk;

  delay_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_size(alloc_size), .alloc_init(alloc_init),
    .full_reset(full_reset), .alloc_done(alloc_done), .alloc_fail(alloc_fail),
    .alloc_base(alloc_base),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .protocol_error(protocol_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alloc_req = '0; full_reset = '0; alloc_size = '0; alloc_init = '0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    av[0]  = '{req:2'b01, frst:2'b00, done:2'b01, fail:2'b00, size:32'd1000, init:32'd200, b0:21'd0, b1:21'd0};
    av[1]  = '{req:2'b01, frst:2'b00, done:2'b01, fail:2'b00, size:32'd500, init:32'd0, b0:21'd1000, b1:21'd0};
    av[2]  = '{req:2'b10, frst:2'b00, done:2'b10, fail:2'b00, size:32'd10, init:32'd0, b0:21'd1000, b1:21'd0};
    av[3]  = '{req:2'b01, frst:2'b00, done:2'b00, fail:2'b01, size:32'h0020_0000 - 32'd1499, init:32'd0, b0:21'd1000, b1:21'd0};
    av[4]  = '{req:2'b01, frst:2'b00, done:2'b01, fail:2'b00, size:32'h0020_0000 - 32'd1500, init:32'd0, b0:21'd1500, b1:21'd0};
    av[5]  = '{req:2'b01, frst:2'b00, done:2'b00, fail:2'b01, size:32'd1, init:32'd0, b0:21'd1500, b1:21'd0};
    av[6]  = '{req:2'b10, frst:2'b00, done:2'b00, fail:2'b10, size:32'd200, init:32'd300, b0:21'd1500, b1:21'd0};
    av[7]  = '{req:2'b11, frst:2'b00, done:2'b00, fail:2'b11, size:32'd0, init:32'd0, b0:21'd1500, b1:21'd0};
    av[8]  = '{req:2'b10, frst:2'b00, done:2'b00, fail:2'b10, size:32'h0040_0000, init:32'd0, b0:21'd1500, b1:21'd0};
    av[9]  = '{req:2'b11, frst:2'b01, done:2'b10, fail:2'b00, size:32'd4, init:32'd4, b0:21'd0, b1:21'd10};
    av[10] = '{req:2'b01, frst:2'b00, done:2'b01, fail:2'b00, size:32'd4, init:32'd0, b0:21'd0, b1:21'd10};
    av[11] = '{req:2'b11, frst:2'b00, done:2'b11, fail:2'b00, size:32'd5, init:32'd5, b0:21'd4, b1:21'd14};
    av[12] = '{req:2'b00, frst:2'b10, done:2'b00, fail:2'b00, size:32'd0, init:32'd0, b0:21'd4, b1:21'd0};

    do_reset();
    check("reset_done", 64'(alloc_done), 64'd0);
    check("reset_fail", 64'(alloc_fail), 64'd0);
    check("reset_base", 64'(alloc_base), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_perr", 64'(protocol_error), 64'd0);

    for (int i = 0; i < 13; i++) begin
      alloc_req = av[i].req; full_reset = av[i].frst;
      alloc_size = av[i].size; alloc_init = av[i].init;
      tick();
      check($sformatf("alloc_done[%0d]", i), 64'(alloc_done), 64'(av[i].done));
      check($sformatf("alloc_fail[%0d]", i), 64'(alloc_fail), 64'(av[i].fail));
      check($sformatf("alloc_base0[%0d]", i), 64'(alloc_base[BW-1:0]), 64'(av[i].b0));
      check($sformatf("alloc_base1[%0d]", i), 64'(alloc_base[2*BW-1:BW]), 64'(av[i].b1));
    end
    idle();
    tick();
    check("alloc_pulse_drop", 64'({alloc_done, alloc_fail}), 64'd0);

    // round robin with both pipelines reading every cycle; pipeline 0 goes first
    req_valid = 2'b11; req_we = 2'b00; mem_ready = 1'b1;
    req_addr = {21'h15555, 21'h0AAAA};
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_grant[%0d]", k), 64'(req_grant), 64'((k % 2) ? 2'b10 : 2'b01));
      check($sformatf("rr_addr[%0d]", k), 64'(mem_addr),
            64'((k % 2) ? {1'b1, 21'h15555} : {1'b0, 21'h0AAAA}));
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 16'(16'h0100 + k);
      tick();
      check($sformatf("rr_ret_valid[%0d]", k), 64'(rd_valid), 64'((k % 2) ? 2'b10 : 2'b01));
      check($sformatf("rr_ret_data[%0d]", k), 64'(rd_data), 64'(16'h0100 + k));
    end
    mem_rvalid = 1'b0;
    tick();
    check("rr_ret_idle", 64'(rd_valid), 64'd0);

    // fill all outstanding slots from pipeline 0, then a ninth read stalls but a write passes
    req_valid = 2'b01; req_we = 2'b00; mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fill_grant[%0d]", k), 64'(req_grant), 64'd1);
      tick();
    end
    #1;
    check("stall_read", 64'({req_grant, mem_req}), 64'd0);
    req_valid = 2'b11; req_we = 2'b10;
    req_addr = {21'h00123, 21'h00777}; req_wdata = {16'hBEEF, 16'h1234};
    #1;
    check("stall_write_grant", 64'(req_grant), 64'(2'b10));
    check("stall_write_cmd", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 1'b1, 21'h00123, 16'hBEEF}));
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 16'(16'hA000 + k);
      tick();
      check($sformatf("drain_ret[%0d]", k), 64'({rd_valid, rd_data}), 64'({2'b01, 16'(16'hA000 + k)}));
    end

    // read return with nothing outstanding
    mem_rdata = 16'h5555;
    tick();
    check("perr_no_rd_valid", 64'(rd_valid), 64'd0);
    check("perr_set", 64'(protocol_error), 64'd1);
    mem_rvalid = 1'b0;
    tick();
    tick();
    check("perr_sticky", 64'(protocol_error), 64'd1);
    req_valid = 2'b11; req_we = 2'b01; mem_ready = 1'b0;
    #1;
    check("not_ready_no_grant", 64'({req_grant, mem_req}), 64'd0);

    // randomized traffic against a queue-based model of the arbiter and an in-order memory
    do_reset();
    check("perr_cleared", 64'(protocol_error), 64'd0);
    last = 1'b1; exp_rv = 2'b00; exp_rd = '0; last_due = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_rd_valid", 64'(rd_valid), 64'(exp_rv));
      if (exp_rv != 2'b00) check("rnd_rd_data", 64'(rd_data), 64'(exp_rd));
      req_valid = 2'($urandom); req_we = 2'($urandom);
      req_addr = 42'({$urandom(), $urandom()}); req_wdata = $urandom();
      mem_ready = $urandom_range(0, 3) != 0;
      mem_rvalid = rsp.size() > 0 && rsp[0].due <= cyc;
      mem_rdata = mem_rvalid ? rsp[0].data : 16'($urandom());
      #1;
      for (int p = 0; p < 2; p++) cand[p] = req_valid[p] && (req_we[p] || tagq.size() < 8);
      granted = mem_ready && cand != 2'b00;
      w = (cand == 2'b11) ? !last : cand[1];
      check("rnd_grant", 64'(req_grant), 64'(granted ? (w ? 2'b10 : 2'b01) : 2'b00));
      check("rnd_mem_req", 64'(mem_req), 64'(granted));
      if (mem_rvalid) begin
        exp_rv = tagq.pop_front() == 1 ? 2'b10 : 2'b01;
        exp_rd = mem_rdata;
        void'(rsp.pop_front());
      end else exp_rv = 2'b00;
      if (granted) begin
        exp_addr = w ? {1'b1, req_addr[2*BW-1:BW]} : {1'b0, req_addr[BW-1:0]};
        check("rnd_mem_addr", 64'(mem_addr), 64'(exp_addr));
        check("rnd_mem_we", 64'(mem_we), 64'(req_we[w]));
        if (req_we[w]) check("rnd_mem_wdata", 64'(mem_wdata), 64'(w ? req_wdata[31:16] : req_wdata[15:0]));
        else begin
          tagq.push_back(int'(w));
          last_due = (cyc + $urandom_range(1, 10) > last_due) ? cyc + $urandom_range(1, 10) : last_due + 1;
          if (last_due <= cyc) last_due = cyc + 1;
          rsp.push_back('{due:last_due, data:16'($urandom())});
        end
        last = w;
      end
      tick();
    end
    check("rnd_no_perr", 64'(protocol_error), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
